// File: rtl/vdp1_gouraud_span.sv
// vdp1_gouraud_span: span Gouraud engine - serial gradient divide, per-pixel accumulate, biased saturating add
//   CLK, RST_N             clock, asynchronous active-low reset
//   START, LEN, COL_S/E    span load (sampled in IDLE only)
//   BUSY                   engine not idle
//   PIX_VALID/READY/DATA   original pixel stream {MSB, channels}
//   OUT_VALID/READY/DATA   shaded pixel stream {MSB, channels}
//   OUT_LAST               marks the result of the final span pixel
module vdp1_gouraud_span #(
   parameter int CH_W   = 5,
   parameter int NUM_CH = 3,
   parameter int FRAC_W = 13,
   parameter int LEN_W  = 10
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     START,
   input  logic [LEN_W-1:0]         LEN,
   input  logic [NUM_CH*CH_W-1:0]   COL_S,
   input  logic [NUM_CH*CH_W-1:0]   COL_E,
   output logic                     BUSY,
   input  logic                     PIX_VALID,
   output logic                     PIX_READY,
   input  logic [NUM_CH*CH_W:0]     PIX_DATA,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [NUM_CH*CH_W:0]     OUT_DATA,
   output logic                     OUT_LAST
);
   localparam int AW = CH_W + FRAC_W;
   localparam int CW = $clog2(AW + 1);
   typedef enum logic [1:0] {IDLE, DIV, RUN, FLUSH} state_t;
   state_t state_q, state_d;
   logic [LEN_W-1:0] dvs_q, dvs_d, pix_q, pix_d;
   logic [CW-1:0] bit_q, bit_d;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [NUM_CH*CH_W:0] out_data_q, out_data_d;
   logic [NUM_CH*CH_W-1:0] shade;
   logic load, hs, adv, last_pix;
   assign load     = (state_q == IDLE) && START && (LEN != '0);
   assign adv      = !out_valid_q || OUT_READY;
   assign hs       = PIX_VALID && PIX_READY;
   assign last_pix = pix_q == dvs_q;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = (LEN == LEN_W'(1)) ? RUN : DIV;
         DIV:     if (bit_q == CW'(AW - 1)) state_d = RUN;
         RUN:     if (hs && last_pix) state_d = FLUSH;
         FLUSH:   if (out_valid_q && OUT_READY && out_last_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      BUSY      = state_q != IDLE;
      PIX_READY = (state_q == RUN) && adv;
   end
   always_comb begin
      dvs_d       = load ? LEN - LEN_W'(1) : dvs_q;
      bit_d       = load ? '0 : (state_q == DIV) ? bit_q + CW'(1) : bit_q;
      pix_d       = load ? '0 : hs ? pix_q + LEN_W'(1) : pix_q;
      out_valid_d = adv ? hs : out_valid_q;
      out_data_d  = hs ? {PIX_DATA[NUM_CH*CH_W], shade} : out_data_q;
      out_last_d  = adv ? hs && last_pix : out_last_q;
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dvs_q       <= '0;
         bit_q       <= '0;
         pix_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         dvs_q       <= dvs_d;
         bit_q       <= bit_d;
         pix_q       <= pix_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_LAST  = out_last_q;
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CH_W-1:0] cs, ce, px, g, delta;
      logic [AW-1:0] acc_q, acc_d, step_q, step_d;
      logic [LEN_W-1:0] rem_q, rem_d;
      logic [LEN_W:0] trial;
      logic dir_q, dir_d, ge;
      logic [CH_W+1:0] s;
      assign cs    = COL_S[c*CH_W +: CH_W];
      assign ce    = COL_E[c*CH_W +: CH_W];
      assign px    = PIX_DATA[c*CH_W +: CH_W];
      assign delta = (ce < cs) ? cs - ce : ce - cs;
      // step_q doubles as the dividend shift register: its MSB feeds the remainder while quotient bits enter at the LSB
      assign trial = {rem_q, step_q[AW-1]};
      assign ge    = trial >= {1'b0, dvs_q};
      assign g     = acc_q[AW-1 -: CH_W];
      assign s     = {2'b00, px} + {2'b00, g} - (CH_W+2)'(2 ** (CH_W - 1));
      assign shade[c*CH_W +: CH_W] = s[CH_W+1] ? '0 : s[CH_W] ? '1 : s[CH_W-1:0];
      always_comb begin
         dir_d  = dir_q;
         acc_d  = acc_q;
         step_d = step_q;
         rem_d  = rem_q;
         if (load) begin
            dir_d  = ce < cs;
            acc_d  = {cs, 1'b1, {(FRAC_W-1){1'b0}}};
            step_d = (LEN == LEN_W'(1)) ? '0 : {delta, {FRAC_W{1'b0}}};
            rem_d  = '0;
         end else if (state_q == DIV) begin
            rem_d  = ge ? LEN_W'(trial - {1'b0, dvs_q}) : trial[LEN_W-1:0];
            step_d = {step_q[AW-2:0], ge};
         end else if (hs) begin
            acc_d  = dir_q ? acc_q - step_q : acc_q + step_q;
         end
      end
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            dir_q  <= 1'b0;
            acc_q  <= '0;
            step_q <= '0;
            rem_q  <= '0;
         end else begin
            dir_q  <= dir_d;
            acc_q  <= acc_d;
            step_q <= step_d;
            rem_q  <= rem_d;
         end
      end
   end
endmodule
